// File: rtl/video_mnist_seg_color_blend_if.sv
// ---------------------------------------------------------------------------
// video_mnist_seg_color_blend_if
//
// Pixel stream bundle for the segmentation colour overlay stage. One instance
// carries both the input stream (s_axi4s_*) and the output stream (m_axi4s_*).
//
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// A source holding tvalid high keeps all payload signals stable until the
// transfer; tvalid never depends combinationally on tready.
//
// Modports:
//   slave  - the overlay block: consumes s_axi4s_*, produces m_axi4s_*.
//   master - the surrounding pipeline: produces s_axi4s_*, consumes m_axi4s_*.
//
// Signals:
//   s_axi4s_tuser      TUSER_WIDTH    bit 0 = start of frame
//   s_axi4s_tlast      1              end of line
//   s_axi4s_tnumber    TNUMBER_WIDTH  class index
//   s_axi4s_tcount     TCOUNT_WIDTH   confidence count
//   s_axi4s_tdata      TDATA_WIDTH    source pixel
//   s_axi4s_tbinary    1              binarised pixel
//   s_axi4s_tdetection 1              detection flag
//   s_axi4s_tvalid/tready             input handshake
//   m_axi4s_tuser/tlast/tdata         output pixel and sideband
//   m_axi4s_tvalid/tready             output handshake
// ---------------------------------------------------------------------------
interface video_mnist_seg_color_blend_if #(
    parameter int TUSER_WIDTH   = 1,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int TDATA_WIDTH   = 24
);
    logic [TUSER_WIDTH-1:0]   s_axi4s_tuser;
    logic                     s_axi4s_tlast;
    logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber;
    logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount;
    logic [TDATA_WIDTH-1:0]   s_axi4s_tdata;
    logic                     s_axi4s_tbinary;
    logic                     s_axi4s_tdetection;
    logic                     s_axi4s_tvalid;
    logic                     s_axi4s_tready;

    logic [TUSER_WIDTH-1:0]   m_axi4s_tuser;
    logic                     m_axi4s_tlast;
    logic [TDATA_WIDTH-1:0]   m_axi4s_tdata;
    logic                     m_axi4s_tvalid;
    logic                     m_axi4s_tready;

    modport slave (
        input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount,
        input  s_axi4s_tdata, s_axi4s_tbinary, s_axi4s_tdetection, s_axi4s_tvalid,
        output s_axi4s_tready,
        output m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
        input  m_axi4s_tready
    );

    modport master (
        output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount,
        output s_axi4s_tdata, s_axi4s_tbinary, s_axi4s_tdetection, s_axi4s_tvalid,
        input  s_axi4s_tready,
        input  m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
        output m_axi4s_tready
    );
endinterface

// File: rtl/video_mnist_seg_color_blend.sv
// ---------------------------------------------------------------------------
// video_mnist_seg_color_blend
//
// Segmentation colour overlay. Per pixel, picks a class colour from a run-time
// writable palette and either replaces the source pixel with it or alpha-blends
// it onto the source. mode/th/alpha are latched on each start-of-frame beat and
// the number of overlaid pixels per frame is published on the next SOF.
//
// Build option: define VIDEO_MNIST_SEG_COLOR_BLEND_EN to enable alpha blending;
// without it an overlaid pixel is simply replaced by the palette colour.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   param_mode      [0] binary view, [1] overlay enable, [2] ignore detection
//   param_th        confidence count threshold
//   param_alpha     blend weight, clamped to 2^ALPHA_WIDTH
//   pal_we/addr/wdata  palette write port
//   axi             pixel streams (slave modport)
//   stat_count      overlaid pixels in the last completed frame
//   stat_valid      one-cycle pulse when stat_count updates
//
// Pipeline: st0 decode/palette/shadow, st1 weight products, st2 sum + output.
// All three stages advance together on cke = m_tready || !m_tvalid.
// ---------------------------------------------------------------------------
module video_mnist_seg_color_blend #(
    parameter int TUSER_WIDTH     = 1,
    parameter int COMPONENTS      = 3,
    parameter int COMPONENT_WIDTH = 8,
    parameter int TNUMBER_WIDTH   = 4,
    parameter int TCOUNT_WIDTH    = 4,
    parameter int NUM_CLASSES     = 11,
    parameter int ALPHA_WIDTH     = 4,
    parameter int STAT_WIDTH      = 24,
    parameter int TDATA_WIDTH     = COMPONENTS * COMPONENT_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [2:0]                param_mode,
    input  logic [TCOUNT_WIDTH-1:0]   param_th,
    input  logic [ALPHA_WIDTH:0]      param_alpha,
    input  logic                      pal_we,
    input  logic [TNUMBER_WIDTH-1:0]  pal_addr,
    input  logic [TDATA_WIDTH-1:0]    pal_wdata,
    video_mnist_seg_color_blend_if.slave axi,
    output logic [STAT_WIDTH-1:0]     stat_count,
    output logic                      stat_valid
);

    localparam logic [ALPHA_WIDTH:0]   ALPHA_ONE     = (ALPHA_WIDTH+1)'(1) << ALPHA_WIDTH;
    localparam logic [TNUMBER_WIDTH:0] NUM_CLASSES_W = (TNUMBER_WIDTH+1)'(NUM_CLASSES);

    function automatic logic [TDATA_WIDTH-1:0] default_color(input int idx);
        logic [23:0] c;
        c = 24'h000000;
        case (idx)
            0:       c = 24'he60012;
            1:       c = 24'h920783;
            2:       c = 24'h1d2088;
            3:       c = 24'h0068b7;
            4:       c = 24'h00a0e9;
            5:       c = 24'h009e96;
            6:       c = 24'h009944;
            7:       c = 24'h8fc31f;
            8:       c = 24'hfff100;
            9:       c = 24'hf39800;
            default: c = 24'h000000;
        endcase
        if (COMPONENTS == 3 && COMPONENT_WIDTH == 8) begin
            return TDATA_WIDTH'(c);
        end
        return '0;
    endfunction

    // ---------------------------------------------------------------- control
    logic cke;
    logic accept;
    logic sof_in;

    assign cke                = axi.m_axi4s_tready || !axi.m_axi4s_tvalid;
    assign axi.s_axi4s_tready = cke;
    assign accept             = axi.s_axi4s_tvalid && cke;
    assign sof_in             = axi.s_axi4s_tuser[0];

    // ---------------------------------------------------------------- palette
    logic [TDATA_WIDTH-1:0] palette [NUM_CLASSES];

    // Writes land on the clock edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                palette[i] <= default_color(i);
            end
        end else if (pal_we && ({1'b0, pal_addr} < NUM_CLASSES_W)) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

    // ------------------------------------------------------- shadow registers
    logic [2:0]              mode_q;
    logic [TCOUNT_WIDTH-1:0] th_q;
    logic [2:0]              eff_mode;
    logic [TCOUNT_WIDTH-1:0] eff_th;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q <= 3'd0;
            th_q   <= '0;
        end else if (accept && sof_in) begin
            mode_q <= param_mode;
            th_q   <= param_th;
        end
    end

`ifdef VIDEO_MNIST_SEG_COLOR_BLEND_EN
    logic [ALPHA_WIDTH:0] alpha_q;
    logic [ALPHA_WIDTH:0] alpha_clamped;
    logic [ALPHA_WIDTH:0] eff_alpha;

    assign alpha_clamped = (param_alpha > ALPHA_ONE) ? ALPHA_ONE : param_alpha;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            alpha_q <= ALPHA_ONE;
        end else if (accept && sof_in) begin
            alpha_q <= alpha_clamped;
        end
    end

    // The SOF beat itself already uses the freshly presented weight.
    assign eff_alpha = sof_in ? alpha_clamped : alpha_q;
`else
    logic unused_alpha;
    assign unused_alpha = ^param_alpha;
`endif

    // ------------------------------------------------------------ st0 decode
    logic                   class_ok;
    logic                   en_in;
    logic [TDATA_WIDTH-1:0] src_in;
    logic [TDATA_WIDTH-1:0] col_in;
    logic [TDATA_WIDTH-1:0] mix_in;

    always_comb begin
        eff_mode = sof_in ? param_mode : mode_q;
        eff_th   = sof_in ? param_th   : th_q;
        src_in   = eff_mode[0] ? {TDATA_WIDTH{axi.s_axi4s_tbinary}} : axi.s_axi4s_tdata;
        class_ok = ({1'b0, axi.s_axi4s_tnumber} < NUM_CLASSES_W);
        col_in   = class_ok ? palette[axi.s_axi4s_tnumber] : axi.s_axi4s_tdata;
        en_in    = eff_mode[1] && (axi.s_axi4s_tcount >= eff_th) &&
                   (axi.s_axi4s_tdetection || eff_mode[2]);
        // When not overlaid, blending src with itself yields src exactly, so the
        // later stages need no separate enable.
        mix_in   = en_in ? col_in : src_in;
    end

    logic                   v0;
    logic [TUSER_WIDTH-1:0] u0;
    logic                   l0;
    logic [TDATA_WIDTH-1:0] mix0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v0   <= 1'b0;
            u0   <= '0;
            l0   <= 1'b0;
            mix0 <= '0;
        end else if (cke) begin
            v0   <= axi.s_axi4s_tvalid;
            u0   <= axi.s_axi4s_tuser;
            l0   <= axi.s_axi4s_tlast;
            mix0 <= mix_in;
        end
    end

    // ------------------------------------------------------------ statistics
    logic [STAT_WIDTH-1:0] cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q      <= '0;
            stat_count <= '0;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (accept) begin
                if (sof_in) begin
                    stat_count <= cnt_q;
                    stat_valid <= 1'b1;
                    cnt_q      <= {{(STAT_WIDTH-1){1'b0}}, en_in};
                end else if (en_in && (cnt_q != {STAT_WIDTH{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------ st1 / st2 datapath
    logic                   v1;
    logic [TUSER_WIDTH-1:0] u1;
    logic                   l1;
    logic [TDATA_WIDTH-1:0] out_d;

`ifdef VIDEO_MNIST_SEG_COLOR_BLEND_EN
    localparam int PW = COMPONENT_WIDTH + ALPHA_WIDTH + 1;

    logic [TDATA_WIDTH-1:0]           src0;
    logic [ALPHA_WIDTH:0]             a0;
    logic [COMPONENTS-1:0][PW-1:0]    ps_d;
    logic [COMPONENTS-1:0][PW-1:0]    pc_d;
    logic [COMPONENTS-1:0][PW-1:0]    ps1;
    logic [COMPONENTS-1:0][PW-1:0]    pc1;
    logic [PW-1:0]                    sum;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            src0 <= '0;
            a0   <= ALPHA_ONE;
        end else if (cke) begin
            src0 <= src_in;
            a0   <= eff_alpha;
        end
    end

    always_comb begin
        for (int c = 0; c < COMPONENTS; c++) begin
            ps_d[c] = PW'(src0[c*COMPONENT_WIDTH +: COMPONENT_WIDTH]) * PW'(ALPHA_ONE - a0);
            pc_d[c] = PW'(mix0[c*COMPONENT_WIDTH +: COMPONENT_WIDTH]) * PW'(a0);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ps1 <= '0;
            pc1 <= '0;
        end else if (cke) begin
            ps1 <= ps_d;
            pc1 <= pc_d;
        end
    end

    // Sum of both weights is 2^W, so the sum always fits in PW bits; the
    // shift truncates.
    always_comb begin
        out_d = '0;
        sum   = '0;
        for (int c = 0; c < COMPONENTS; c++) begin
            sum = ps1[c] + pc1[c];
            out_d[c*COMPONENT_WIDTH +: COMPONENT_WIDTH] = sum[ALPHA_WIDTH +: COMPONENT_WIDTH];
        end
    end
`else
    logic [TDATA_WIDTH-1:0] d1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            d1 <= '0;
        end else if (cke) begin
            d1 <= mix0;
        end
    end

    assign out_d = d1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1 <= 1'b0;
            u1 <= '0;
            l1 <= 1'b0;
        end else if (cke) begin
            v1 <= v0;
            u1 <= u0;
            l1 <= l0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axi.m_axi4s_tvalid <= 1'b0;
            axi.m_axi4s_tuser  <= '0;
            axi.m_axi4s_tlast  <= 1'b0;
            axi.m_axi4s_tdata  <= '0;
        end else if (cke) begin
            axi.m_axi4s_tvalid <= v1;
            axi.m_axi4s_tuser  <= u1;
            axi.m_axi4s_tlast  <= l1;
            axi.m_axi4s_tdata  <= out_d;
        end
    end

endmodule

// File: tb/tb_video_mnist_seg_color_blend.sv
// ---------------------------------------------------------------------------
// tb_video_mnist_seg_color_blend
//
// Bench for the segmentation colour overlay. Directed frames followed by a
// randomized stream with random output backpressure. A reference model of the
// pixel rules predicts each output beat and each per-frame statistic.
// ---------------------------------------------------------------------------
module tb_video_mnist_seg_color_blend;

    localparam int TDW = 24;
    localparam int W   = 26;  // {tuser, tlast, tdata}

    // ---------------------------------------------------------- clock/reset
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [2:0]     param_mode  = 3'd0;
    logic [3:0]     param_th    = 4'd0;
    logic [4:0]     param_alpha = 5'd16;
    logic           pal_we      = 1'b0;
    logic [3:0]     pal_addr    = 4'd0;
    logic [TDW-1:0] pal_wdata   = '0;
    logic [23:0]    stat_count;
    logic           stat_valid;

    video_mnist_seg_color_blend_if #(
        .TUSER_WIDTH(1), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(4), .TDATA_WIDTH(TDW)
    ) axi ();

    video_mnist_seg_color_blend dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .param_mode  (param_mode),
        .param_th    (param_th),
        .param_alpha (param_alpha),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .axi         (axi),
        .stat_count  (stat_count),
        .stat_valid  (stat_valid)
    );

    // ---------------------------------------------------------- scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0]   exp_q[$];
    int             acc_q[$];
    logic [23:0]    pal_m [0:10];
    logic [2:0]     mode_m;
    int             th_m;
    int             alpha_m;
    int             cnt_m;
    bit             stat_pending;
    int             stat_exp;
    bit             held_flag;
    logic [W-1:0]   held;
    logic [TDW-1:0] last_out;
    int             cyc;
    bit             bp_en     = 0;
    bit             lat_check = 1;

    localparam logic [23:0] DEF_PAL [0:10] = '{
        24'he60012, 24'h920783, 24'h1d2088, 24'h0068b7, 24'h00a0e9, 24'h009e96,
        24'h009944, 24'h8fc31f, 24'hfff100, 24'hf39800, 24'h000000
    };

    function automatic logic [23:0] model_pixel(
        input logic [2:0] md, input int th, input int alpha, input int num, input int cnt,
        input logic [23:0] data, input logic bin, input logic det, output logic en);
        logic [23:0] src;
        logic [23:0] col;
        logic [23:0] res;
        src = md[0] ? (bin ? 24'hffffff : 24'h000000) : data;
        if (num < 11) col = pal_m[num];
        else          col = data;
        en  = md[1] && (cnt >= th) && (det || md[2]);
        res = src;
        if (en) begin
`ifdef VIDEO_MNIST_SEG_COLOR_BLEND_EN
            for (int c = 0; c < 3; c++) begin
                int s;
                int k;
                s = int'(src[c*8 +: 8]);
                k = int'(col[c*8 +: 8]);
                res[c*8 +: 8] = 8'((s * (16 - alpha) + k * alpha) / 16);
            end
`else
            res = col;
`endif
        end
        return res;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < 11; i++) pal_m[i] = DEF_PAL[i];
        mode_m       = 3'd0;
        th_m         = 0;
        alpha_m      = 16;
        cnt_m        = 0;
        stat_pending = 0;
        held_flag    = 0;
    endtask

    // Monitor: everything is sampled mid-cycle, when handshake signals are stable.
    always @(negedge aclk) begin
        if (aresetn) begin
            logic          en;
            logic [23:0]   px;
            logic [W-1:0]  got;
            cyc++;
            // statistics pulse expected one cycle after an accepted SOF
            if (stat_pending || stat_valid) begin
                check("stat_valid", stat_valid, stat_pending);
                if (stat_pending) check("stat_count", stat_count, stat_exp);
            end
            stat_pending = 0;

            got = {axi.m_axi4s_tuser, axi.m_axi4s_tlast, axi.m_axi4s_tdata};
            if (held_flag) check("hold_stable", {axi.m_axi4s_tvalid, got}, {1'b1, held});
            held_flag = axi.m_axi4s_tvalid && !axi.m_axi4s_tready;
            held      = got;

            if (axi.m_axi4s_tvalid && axi.m_axi4s_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", got, 0);
                end else begin
                    int acc;
                    check("pixel", got, exp_q.pop_front());
                    acc = acc_q.pop_front();
                    if (lat_check) check("latency", cyc - acc, 3);
                end
                last_out = axi.m_axi4s_tdata;
            end

            if (axi.s_axi4s_tvalid && axi.s_axi4s_tready) begin
                if (axi.s_axi4s_tuser[0]) begin
                    mode_m  = param_mode;
                    th_m    = int'(param_th);
                    alpha_m = (param_alpha > 5'd16) ? 16 : int'(param_alpha);
                end
                px = model_pixel(mode_m, th_m, alpha_m, int'(axi.s_axi4s_tnumber),
                                 int'(axi.s_axi4s_tcount), axi.s_axi4s_tdata,
                                 axi.s_axi4s_tbinary, axi.s_axi4s_tdetection, en);
                exp_q.push_back({axi.s_axi4s_tuser, axi.s_axi4s_tlast, px});
                acc_q.push_back(cyc);
                if (axi.s_axi4s_tuser[0]) begin
                    stat_pending = 1;
                    stat_exp     = cnt_m;
                    cnt_m        = en ? 1 : 0;
                end else if (en) begin
                    cnt_m++;
                end
            end

            if (pal_we && pal_addr < 4'd11) pal_m[pal_addr] = pal_wdata;
        end
    end

    // Downstream ready: always ready unless backpressure is enabled.
    always begin
        @(posedge aclk);
        #1;
        axi.m_axi4s_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------------------------------------------------- driver tasks
    task automatic do_reset();
        aresetn = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        check("rst_tvalid", axi.m_axi4s_tvalid, 0);
        check("rst_tdata", axi.m_axi4s_tdata, 0);
        check("rst_tuser_tlast", {axi.m_axi4s_tuser, axi.m_axi4s_tlast}, 0);
        check("rst_stat", {stat_valid, stat_count}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic send(input logic sof, input logic last, input int num, input int cnt,
                        input logic [23:0] data, input logic bin, input logic det);
        int guard;
        axi.s_axi4s_tuser      = sof;
        axi.s_axi4s_tlast      = last;
        axi.s_axi4s_tnumber    = 4'(num);
        axi.s_axi4s_tcount     = 4'(cnt);
        axi.s_axi4s_tdata      = data;
        axi.s_axi4s_tbinary    = bin;
        axi.s_axi4s_tdetection = det;
        axi.s_axi4s_tvalid     = 1'b1;
        guard = 0;
        @(negedge aclk);
        while (!axi.s_axi4s_tready && guard < 200) begin
            guard++;
            @(negedge aclk);
        end
        if (guard >= 200) check("accept_timeout", 1, 0);
        @(posedge aclk);
        #1;
        axi.s_axi4s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pal_write(input int addr, input logic [23:0] data);
        pal_we    = 1'b1;
        pal_addr  = 4'(addr);
        pal_wdata = data;
        @(posedge aclk);
        #1;
        pal_we = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            guard++;
            @(negedge aclk);
        end
        check("drain", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic set_params(input logic [2:0] md, input int th, input int alpha);
        param_mode  = md;
        param_th    = 4'(th);
        param_alpha = 5'(alpha);
    endtask

    // ---------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- main sequence
    initial begin
        axi.s_axi4s_tvalid     = 1'b0;
        axi.s_axi4s_tuser      = 1'b0;
        axi.s_axi4s_tlast      = 1'b0;
        axi.s_axi4s_tnumber    = 4'd0;
        axi.s_axi4s_tcount     = 4'd0;
        axi.s_axi4s_tdata      = '0;
        axi.s_axi4s_tbinary    = 1'b0;
        axi.s_axi4s_tdetection = 1'b0;
        axi.m_axi4s_tready     = 1'b1;
        cyc      = 0;
        last_out = '0;

        do_reset();
        check("rst_tready", axi.s_axi4s_tready, 1);

        // Palette defaults after reset, replace mode
        set_params(3'd2, 0, 16);
        send(1, 0, 3, 0, 24'h102030, 0, 1);
        drain();
        check("default_pal3", last_out, 24'h0068b7);

        // Blend at half weight
        pal_write(0, 24'hff0000);
        set_params(3'd2, 0, 8);
        send(1, 0, 0, 5, 24'h000080, 0, 1);
        drain();
`ifdef VIDEO_MNIST_SEG_COLOR_BLEND_EN
        check("blend_half", last_out, 24'h7f0040);
`else
        check("blend_half", last_out, 24'hff0000);
`endif

        // Per-frame latching: mode change mid-frame takes effect at next SOF
        set_params(3'd2, 0, 16);
        send(1, 0, 1, 4, 24'h111111, 0, 1);
        send(0, 0, 1, 4, 24'h222222, 0, 1);
        param_mode = 3'd0;
        send(0, 0, 1, 4, 24'h333333, 0, 1);
        send(0, 1, 1, 4, 24'h444444, 0, 1);
        drain();
        check("latch_midframe", last_out, 24'h920783);
        send(1, 0, 1, 4, 24'h555555, 0, 1);
        drain();
        check("latch_newframe", last_out, 24'h555555);

        // Out-of-range class, threshold miss, binary view
        set_params(3'd2, 0, 16);
        send(1, 0, 12, 9, 24'h123456, 0, 1);
        drain();
        check("class_oor", last_out, 24'h123456);
        set_params(3'd2, 3, 16);
        send(1, 0, 1, 2, 24'h0a0b0c, 0, 1);
        drain();
        check("below_th", last_out, 24'h0a0b0c);
        set_params(3'd3, 3, 16);
        send(1, 0, 1, 2, 24'h000000, 1, 1);
        drain();
        check("binary_view", last_out, 24'hffffff);

        // Palette write while streaming class 5, plus an ignored write to 11
        set_params(3'd2, 0, 16);
        fork
            begin
                send(1, 0, 5, 7, 24'h010101, 0, 1);
                for (int i = 0; i < 9; i++) send(0, 0, 5, 7, 24'h020202, 0, 1);
            end
            begin
                idle(4);
                pal_write(5, 24'habcdef);
                pal_write(11, 24'h5a5a5a);
            end
        join
        drain();
        check("pal_write5", last_out, 24'habcdef);
        for (int k = 0; k < 12; k++) send(k == 0, 0, k, 9, 24'h0f0f0f, 0, 1);
        drain();
        check("pal_addr11_ignored", last_out, 24'h0f0f0f);

        // Reset with pixels in flight: nothing may come out afterwards
        send(1, 0, 2, 9, 24'h777777, 0, 1);
        send(0, 0, 2, 9, 24'h888888, 0, 1);
        do_reset();
        idle(8);
        check("post_reset_empty", exp_q.size(), 0);
        check("post_reset_tvalid", axi.m_axi4s_tvalid, 0);

        // Randomized stream with backpressure
        lat_check = 0;
        bp_en     = 1;
        for (int f = 0; f < 20; f++) begin
            for (int p = 0; p < 50; p++) begin
                if ($urandom_range(0, 9) == 0) begin
                    set_params(3'($urandom_range(0, 7)), $urandom_range(0, 15),
                               $urandom_range(0, 31));
                end
                if ($urandom_range(0, 3) == 0) idle(1);
                send(p == 0, (p % 10) == 9, $urandom_range(0, 15), $urandom_range(0, 15),
                     24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        send(1, 0, 0, 0, 24'h000000, 0, 0);
        drain();
        bp_en = 0;
        idle(4);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_mnist_seg_color_blend.md
# video_mnist_seg_color_blend

Parametrised successor to the MNIST segmentation colour overlay stage. It sits between the classifier/detection pipeline and the video output. Per pixel, it selects a class colour from a run-time writable palette and either replaces the source pixel with it or alpha-blends it onto the source. Control parameters are latched per frame, and the block reports a per-frame count of overlaid pixels.

## Interface
- TUSER_WIDTH, 1: user sideband width; bit 0 is start-of-frame (SOF).
- COMPONENTS, 3: colour components per pixel.
- COMPONENT_WIDTH, 8: bits per component; TDATA_WIDTH = COMPONENTS*COMPONENT_WIDTH.
- TNUMBER_WIDTH, 4: class index width.
- TCOUNT_WIDTH, 4: confidence count width.
- NUM_CLASSES, 11: number of palette entries, at most 2^TNUMBER_WIDTH.
- ALPHA_WIDTH, 4: blend fraction bits (W).
- STAT_WIDTH, 24: overlay pixel counter width.
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low; all state is cleared immediately on assertion.
- param_mode  in  3  [0] binary view, [1] overlay enable, [2] ignore detection flag.
- param_th  in  TCOUNT_WIDTH  count threshold.
- param_alpha  in  ALPHA_WIDTH+1  blend weight; values above 2^W are clamped to 2^W.
- pal_we  in  1  palette write strobe.
- pal_addr  in  TNUMBER_WIDTH  palette index.
- pal_wdata  in  TDATA_WIDTH  palette colour.
- s_axi4s_tuser/tlast/tnumber/tcount/tdata/tbinary/tdetection/tvalid  in  as named  input pixel stream.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser/tlast/tdata/tvalid  out  as named  output pixel stream.
- m_axi4s_tready  in  1  downstream ready.
- stat_count  out  STAT_WIDTH  overlaid pixels in the last completed frame.
- stat_valid  out  1  one-cycle pulse when stat_count updates.

## Operation
- Accept: an input beat is accepted when s_axi4s_tvalid && s_axi4s_tready.
- Shadow registers: on an accepted beat with tuser[0]=1, mode, th and alpha (clamped) load from the live ports. That beat already uses the new values through a bypass. Mid-frame port changes are ignored.
- Source select: src = mode[0] ? every bit replicated from tbinary : tdata.
- Overlay enable: en = mode[1] && (tcount >= th) && (tdetection || mode[2]). The comparison is unsigned.
- Colour select:
  - tnumber < NUM_CLASSES: col = palette[tnumber].
  - Otherwise: col = tdata, the raw input pixel, even in binary view.
- Output pixel:
  - en=0: output = src.
  - en=1: output = blend(src, col), defined under Configuration.
- Palette writes:
  - Writes are immediate and independent of the stream.
  - A pal_addr >= NUM_CLASSES is ignored.
  - A lookup in the same cycle as a write to the same index returns the old value.
- Palette reset contents:
  - COMPONENTS=3 and COMPONENT_WIDTH=8: entries 0..9 = e60012, 920783, 1d2088, 0068b7, 00a0e9, 009e96, 009944, 8fc31f, fff100, f39800.
  - Remaining entries, and all entries for other geometries: zero.
- Statistics:
  - A counter increments on every accepted beat with en=1, saturating at 2^STAT_WIDTH-1.
  - On an accepted SOF beat: stat_count <= counter, stat_valid = 1 for one cycle, and the counter restarts at en of that beat.
  - The first SOF after reset also publishes (value 0 if no beats were counted).
- tuser and tlast pass through aligned with their pixel.

## Timing
- Pipeline: 3 register stages.
  - st0: decode, palette read, shadow apply.
  - st1: weight products.
  - st2: sum, shift, output register.
- Latency: 3 accepted-advance cycles from input to output.
- Clock enable: cke = m_axi4s_tready || !m_axi4s_tvalid. s_axi4s_tready = cke. All stages advance together on cke.
- Bubbles: an invalid beat propagates as tvalid=0. Stalled stages hold their data exactly.
- Throughput: one pixel per clock with no backpressure.
- Reset values:
  - Outputs: m_axi4s_tvalid 0, m_axi4s_tdata 0, m_axi4s_tuser 0, m_axi4s_tlast 0, stat_count 0, stat_valid 0.
  - Shadow registers: mode 0, th 0, alpha 2^W.
  - Palette: defaults as above. Counter: 0.
- Reset mid-frame: in-flight pixels are discarded, and nothing is emitted until new input arrives.
- Simultaneous SOF and palette write: the pixel uses the old palette value and the new shadow parameters.

## Configuration
- VIDEO_MNIST_SEG_COLOR_BLEND_EN defined:
  - Per component: out = (src*(2^W - a) + col*a) >> W, where a = shadow alpha.
  - The intermediate is COMPONENT_WIDTH+W+1 bits wide; the result is truncated, not rounded.
  - a=0 gives src; a=2^W gives col exactly.
- Undefined:
  - out = col when en=1. param_alpha is ignored and no multipliers are instantiated.
  - Latency remains 3 cycles.

## Test plan
- Reset defaults: mode=2, th=0, tnumber=3, tdetection=1, alpha=16 (W=4), SOF pixel tdata=102030 -> output 0068b7 three cycles after acceptance; stat_count=0 with stat_valid pulse on that SOF.
- Blend: alpha=8, palette[0]=ff0000, src 000080, en=1 -> output 7f0040 with BLEND_EN defined; ff0000 without it.
- Per-frame latching: change mode from 2 to 0 mid-frame -> overlay continues until the next SOF, then output equals tdata.
- Out-of-range class and threshold: tnumber=12 -> output equals tdata; tcount=2 with th=3 -> output equals src; binary mode with tbinary=1 -> ffffff.
- Backpressure: random m_axi4s_tready over 1000 pixels -> no loss, duplication or reorder; held data stable while stalled; stat_count equals the reference count of en=1 beats per frame.
- Palette write: write palette[5]=abcdef while streaming class 5 -> colour changes on the beat accepted after the write cycle; write to addr 11 -> no effect.
